// File: rtl/col_burst_sequencer.sv
// -----------------------------------------------------------------------------
// col_burst_sequencer
//
// Registered column-burst sequencer. A request carries a start column, a beat
// count minus one and a wrap mode. One beat is stepped through consecutive
// columns per cycle. Each beat drives a one-hot column select and its binary
// column address. The burst ends with a single-cycle done pulse; trunc
// accompanies done when a non-wrapping burst was cut short at the top column.
//
// Optional feature: define COL_PRECHARGE_GAP_EN to insert one idle GAP cycle
// (select lines low) after every non-final beat, giving bitline precharge time.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   req_valid   burst request present
//   req_ready   request accepted this cycle (high only in IDLE)
//   req_addr    start column
//   req_len     beats minus one
//   req_wrap    1 = wrap modulo NUM_COLS, 0 = truncate at column NUM_COLS-1
//   stall       hold the current beat
//   col_select  registered one-hot column select, zero when no beat
//   col_addr    binary address of the current beat
//   beat_valid  col_select/col_addr carry a live beat
//   last        current beat is the final one
//   done        one-cycle pulse after the final beat completes
//   trunc       valid with done: burst ended early because wrap was 0
//
// NUM_COLS must equal 2**ADDR_WIDTH.
// -----------------------------------------------------------------------------
module col_burst_sequencer #(
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_COLS   = 16,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic                  req_wrap,
  input  logic                  stall,
  output logic [NUM_COLS-1:0]   col_select,
  output logic [ADDR_WIDTH-1:0] col_addr,
  output logic                  beat_valid,
  output logic                  last,
  output logic                  done,
  output logic                  trunc
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1
`ifdef COL_PRECHARGE_GAP_EN
    ,
    S_GAP    = 2'd2
`endif
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(NUM_COLS - 1);

  state_t                 state_reg;
  logic [ADDR_WIDTH-1:0]  addr_reg;
  logic [LEN_WIDTH-1:0]   rem_reg;
  logic                   wrap_reg;
  logic [NUM_COLS-1:0]    select_reg;
  logic                   beat_valid_reg;
  logic                   last_reg;
  logic                   done_reg;
  logic                   trunc_reg;

  logic [ADDR_WIDTH-1:0]  addr_next;
  logic [LEN_WIDTH-1:0]   rem_next;

  // Successor beat: natural ADDR_WIDTH-bit wrap on the address. The count
  // never underflows because a beat with rem_reg == 0 is always the last.
  assign addr_next = addr_reg + ADDR_WIDTH'(1);
  assign rem_next  = rem_reg - LEN_WIDTH'(1);

  function automatic logic [NUM_COLS-1:0] onehot(input logic [ADDR_WIDTH-1:0] a);
    logic [NUM_COLS-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  // A beat is final when the count is exhausted or a non-wrapping burst has
  // reached the top column.
  function automatic logic beat_is_last(input logic [LEN_WIDTH-1:0]  rem,
                                        input logic                  wrap,
                                        input logic [ADDR_WIDTH-1:0] a);
    return (rem == '0) || (!wrap && (a == LAST_COL));
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      addr_reg       <= '0;
      rem_reg        <= '0;
      wrap_reg       <= 1'b0;
      select_reg     <= '0;
      beat_valid_reg <= 1'b0;
      last_reg       <= 1'b0;
      done_reg       <= 1'b0;
      trunc_reg      <= 1'b0;
    end else begin
      // done/trunc are single-cycle pulses unless re-armed below.
      done_reg  <= 1'b0;
      trunc_reg <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (req_valid) begin
            state_reg      <= S_ACTIVE;
            addr_reg       <= req_addr;
            rem_reg        <= req_len;
            wrap_reg       <= req_wrap;
            select_reg     <= onehot(req_addr);
            beat_valid_reg <= 1'b1;
            last_reg       <= beat_is_last(req_len, req_wrap, req_addr);
          end
        end

        S_ACTIVE: begin
          // With stall high every register simply holds its value.
          if (!stall) begin
            if (last_reg) begin
              state_reg      <= S_IDLE;
              select_reg     <= '0;
              beat_valid_reg <= 1'b0;
              last_reg       <= 1'b0;
              done_reg       <= 1'b1;
              trunc_reg      <= (rem_reg != '0);
            end else begin
              addr_reg <= addr_next;
              rem_reg  <= rem_next;
`ifdef COL_PRECHARGE_GAP_EN
              state_reg      <= S_GAP;
              select_reg     <= '0;
              beat_valid_reg <= 1'b0;
              last_reg       <= 1'b0;
`else
              select_reg     <= onehot(addr_next);
              last_reg       <= beat_is_last(rem_next, wrap_reg, addr_next);
`endif
            end
          end
        end

`ifdef COL_PRECHARGE_GAP_EN
        // Exactly one precharge cycle; stall is deliberately not honoured here.
        S_GAP: begin
          state_reg      <= S_ACTIVE;
          select_reg     <= onehot(addr_reg);
          beat_valid_reg <= 1'b1;
          last_reg       <= beat_is_last(rem_reg, wrap_reg, addr_reg);
        end
`endif

        default: begin
          state_reg      <= S_IDLE;
          select_reg     <= '0;
          beat_valid_reg <= 1'b0;
          last_reg       <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = (state_reg == S_IDLE);
  assign col_select = select_reg;
  assign col_addr   = addr_reg;
  assign beat_valid = beat_valid_reg;
  assign last       = last_reg;
  assign done       = done_reg;
  assign trunc      = trunc_reg;

endmodule

// File: tb/tb_col_burst_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for col_burst_sequencer. A driver issues directed and random
// bursts; for each accepted request a reference model expands the burst into
// its expected beat list plus a final done record and pushes them into a
// scoreboard queue. An independent monitor pops and compares whenever the DUT
// presents a completing beat or a done pulse.
// -----------------------------------------------------------------------------
module tb_col_burst_sequencer;

  localparam int AW = 4;
  localparam int NC = 16;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic          req_wrap;
  logic          stall;
  logic [NC-1:0] col_select;
  logic [AW-1:0] col_addr;
  logic          beat_valid;
  logic          last;
  logic          done;
  logic          trunc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit      is_done;
    int      addr;
    bit      last;
    bit      trunc;
  } exp_t;

  exp_t sb[$];

  col_burst_sequencer #(.ADDR_WIDTH(AW), .NUM_COLS(NC), .LEN_WIDTH(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .req_wrap   (req_wrap),
    .stall      (stall),
    .col_select (col_select),
    .col_addr   (col_addr),
    .beat_valid (beat_valid),
    .last       (last),
    .done       (done),
    .trunc      (trunc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, required, $time);
    end
  endtask

  // Reference model: expand a request into the sequence of columns it visits.
  task automatic model_push(input int addr, input int len, input bit wrap);
    exp_t e;
    int   issued;
    issued = 0;
    for (int i = 0; i <= len; i++) begin
      int raw;
      raw = addr + i;
      if (!wrap && raw > NC - 1) break;
      e.is_done = 1'b0;
      e.addr    = raw % NC;
      e.last    = (i == len) || (!wrap && raw == NC - 1);
      e.trunc   = 1'b0;
      sb.push_back(e);
      issued++;
    end
    e.is_done = 1'b1;
    e.addr    = 0;
    e.last    = 1'b0;
    e.trunc   = (issued != len + 1);
    sb.push_back(e);
  endtask

  // Monitor: compare on the falling edge, consume a beat only when it
  // completes (stall low), consume a done record on each done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      check("onehot_or_zero", ($countones(col_select) <= 1), 1);
      if (beat_valid) begin
        if (sb.size() == 0 || sb[0].is_done) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got col_addr %0d, expected no beat at %0t", col_addr, $time);
        end else begin
          check("beat_addr",   col_addr,   sb[0].addr);
          check("beat_select", col_select, 1 << sb[0].addr);
          check("beat_last",   last,       sb[0].last);
          if (!stall) void'(sb.pop_front());
        end
      end else begin
        check("idle_select_zero", col_select, 0);
      end
      if (done) begin
        if (sb.size() == 0 || !sb[0].is_done) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1, expected a beat or nothing at %0t", $time);
        end else begin
          check("done_trunc", trunc, sb[0].trunc);
          void'(sb.pop_front());
        end
      end
    end
  end

  // Issue one burst and run it to completion. stall_mode: 0 none, 1 random,
  // 2 stall on beat index 1 for three cycles. Junk requests are pulsed while
  // the DUT is busy and must be ignored.
  task automatic run_burst(input int addr, input int len, input bit wrap,
                           input int stall_mode, input bit junk);
    int k;
    req_valid = 1'b1;
    req_addr  = AW'(addr);
    req_len   = LW'(len);
    req_wrap  = wrap;
    stall     = 1'b0;
    model_push(addr, len, wrap);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("first_beat_valid", beat_valid, 1);
    check("first_beat_addr",  col_addr,   addr);
    k = 0;
    while (!req_ready) begin
      if (k >= 300) begin
        checks++;
        errors++;
        $display("FAIL burst_timeout: got req_ready=0, expected 1 within 300 cycles");
        break;
      end
      case (stall_mode)
        1:       stall = ($urandom_range(0, 3) == 0);
        2:       stall = (k >= 1 && k <= 3);
        default: stall = 1'b0;
      endcase
      if (junk) begin
        req_valid = ($urandom_range(0, 2) == 0);
        req_addr  = AW'($urandom);
        req_len   = LW'($urandom);
        req_wrap  = 1'($urandom);
      end
      @(posedge clk); #1;
      k++;
    end
    req_valid = 1'b0;
    stall     = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    req_wrap  = 1'b0;
    stall     = 1'b0;
    #1;
    check("rst_req_ready",  req_ready,  1);
    check("rst_col_select", col_select, 0);
    check("rst_col_addr",   col_addr,   0);
    check("rst_beat_valid", beat_valid, 0);
    check("rst_last",       last,       0);
    check("rst_done",       done,       0);
    check("rst_trunc",      trunc,      0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases from the test plan.
    run_burst(3, 3, 1'b1, 0, 1'b0);   // basic
    run_burst(14, 3, 1'b1, 0, 1'b0);  // wrap
    run_burst(14, 3, 1'b0, 0, 1'b0);  // truncation
    run_burst(0, 2, 1'b1, 2, 1'b1);   // stall + ignored requests
    run_burst(9, 0, 1'b0, 0, 1'b0);   // single beat
    run_burst(0, 1, 1'b1, 0, 1'b0);   // gap pattern when enabled
    run_burst(15, 0, 1'b0, 0, 1'b0);  // top column, single beat, no trunc
    run_burst(2, 15, 1'b1, 1, 1'b0);  // longest wrapping burst
    run_burst(5, 15, 1'b0, 0, 1'b1);  // long truncated burst

    // Reset in the middle of a burst, while beat index 2 is presented.
    req_valid = 1'b1;
    req_addr  = 4'd5;
    req_len   = 4'd6;
    req_wrap  = 1'b1;
    model_push(5, 6, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("midrst_col_select", col_select, 0);
    check("midrst_beat_valid", beat_valid, 0);
    check("midrst_done",       done,       0);
    check("midrst_last",       last,       0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    check("postrst_req_ready", req_ready, 1);
    check("postrst_col_addr",  col_addr,  0);
    @(posedge clk); #1;

    // Randomised bursts.
    for (int n = 0; n < 60; n++) begin
      run_burst(int'($urandom_range(0, NC - 1)), int'($urandom_range(0, 15)),
                1'($urandom), int'($urandom_range(0, 1)), 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
